// File: rtl/segasys1_hiscore_seq.sv
// Hiscore table sequencer for the System 1 core.
// Pauses the core on a VBLK rising edge and then walks the programmed address
// regions. It either streams core RAM bytes out (save) or writes streamed bytes
// into core RAM (load) through the HSAD/HSDI/HSWE/HSDO port.
`timescale 1ns/1ps
module segasys1_hiscore_seq #(
    parameter int NREG   = 4,
    parameter int RDLAT  = 2,
    parameter int SETTLE = 3
) (
    input  logic                    clk48M,
    input  logic                    reset_n,
    input  logic                    cfg_we,
    input  logic [$clog2(NREG)-1:0] cfg_idx,
    input  logic [15:0]             cfg_base,
    input  logic [8:0]              cfg_len,
    input  logic                    start_save,
    input  logic                    start_load,
    input  logic                    abort,
    input  logic                    vblank,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    pause_req,
    output logic [15:0]             hs_addr,
    output logic [7:0]              hs_wdata,
    output logic                    hs_we,
    input  logic [7:0]              hs_rdata,
    output logic [7:0]              so_data,
    output logic                    so_valid,
    input  logic                    so_ready,
    input  logic [7:0]              si_data,
    input  logic                    si_valid,
    output logic                    si_ready
);
    localparam int IW = $clog2(NREG);
    localparam logic [IW:0] REG_END     = (IW+1)'(NREG);
    localparam logic [IW:0] REG_LAST    = (IW+1)'(NREG - 1);
    localparam logic [IW:0] REG_ONE     = (IW+1)'(1);
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [7:0]  RDLAT_LAST  = 8'(RDLAT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WAITVB, S_SETTLE, S_NEXTREG, S_RD_ADDR,
        S_RD_WAIT, S_RD_OUT, S_WR, S_FINISH
    } state_t;

    state_t       state_q, state_d;
    logic [IW:0]  reg_q, reg_d;
    logic [7:0]   off_q, off_d;
    logic [7:0]   cnt_q, cnt_d;
    logic         dir_save_q, err_q, pause_q, vb_q, so_valid_q;
    logic [7:0]   so_data_q;
    logic [15:0]  base_q [NREG];
    logic [8:0]   len_q  [NREG];

    logic [IW-1:0] ridx;
    logic [15:0]   base_cur;
    logic [8:0]    len_cur;
    logic          reg_end, last_byte, vb_rise, settle_last, rdwait_last, step_byte;

    assign ridx        = reg_q[IW-1:0];
    assign base_cur    = base_q[ridx];
    assign len_cur     = len_q[ridx];
    assign reg_end     = (reg_q == REG_END);
    assign last_byte   = ({1'b0, off_q} == (len_cur - 9'd1));
    assign vb_rise     = vblank & ~vb_q;
    assign settle_last = (cnt_q == SETTLE_LAST);
    assign rdwait_last = (cnt_q == RDLAT_LAST);
    assign step_byte   = ((state_q == S_RD_OUT) && so_ready) || ((state_q == S_WR) && si_valid);

    // State register plus the walk counters (settle/read wait, region, offset).
    always_ff @(posedge clk48M or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            reg_q   <= '0;
            off_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; abort overrides everything outside IDLE.
    always_comb begin
        state_d = state_q;
        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    if (start_save || start_load) state_d = S_WAITVB;
                S_WAITVB:  if (vb_rise) state_d = S_SETTLE;
                S_SETTLE:  if (settle_last) state_d = S_NEXTREG;
                S_NEXTREG: begin
                    if (reg_end) begin
                        state_d = S_FINISH;
                    end else if (len_cur == 9'd0) begin
                        // Skipping the last descriptor ends the walk directly, so a
                        // disabled table spends exactly NREG cycles here.
                        if (reg_q == REG_LAST) state_d = S_FINISH;
                    end else begin
                        state_d = dir_save_q ? S_RD_ADDR : S_WR;
                    end
                end
                S_RD_ADDR: state_d = S_RD_WAIT;
                S_RD_WAIT: if (rdwait_last) state_d = S_RD_OUT;
                S_RD_OUT:  if (so_ready) state_d = last_byte ? S_NEXTREG : S_RD_ADDR;
                S_WR:      if (si_valid) state_d = last_byte ? S_NEXTREG : S_WR;
                S_FINISH:  state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Counter, region index and byte offset updates.
    always_comb begin
        cnt_d = cnt_q;
        reg_d = reg_q;
        off_d = off_q;
        case (state_q)
            S_WAITVB:  cnt_d = '0;
            S_SETTLE: begin
                cnt_d = cnt_q + 8'd1;
                if (settle_last) begin
                    reg_d = '0;
                    off_d = '0;
                end
            end
            S_NEXTREG: if (!reg_end && len_cur == 9'd0) reg_d = reg_q + REG_ONE;
            S_RD_ADDR: cnt_d = '0;
            S_RD_WAIT: cnt_d = cnt_q + 8'd1;
            default:   ;
        endcase
        if (step_byte) begin
            if (last_byte) begin
                reg_d = reg_q + REG_ONE;
                off_d = '0;
            end else begin
                off_d = off_q + 8'd1;
            end
        end
    end

    // Control flags and the save-stream output register.
    always_ff @(posedge clk48M or negedge reset_n) begin
        if (!reset_n) begin
            dir_save_q <= 1'b0;
            err_q      <= 1'b0;
            pause_q    <= 1'b0;
            vb_q       <= 1'b0;
            so_valid_q <= 1'b0;
            so_data_q  <= '0;
        end else begin
            vb_q <= vblank;
            if (state_q != S_IDLE && abort) begin
                pause_q    <= 1'b0;
                so_valid_q <= 1'b0;
                err_q      <= 1'b1;
            end else begin
                if (state_q == S_IDLE && (start_save || start_load)) begin
                    dir_save_q <= start_save;
                    err_q      <= 1'b0;
                end
                if (state_q == S_WAITVB && vb_rise) pause_q <= 1'b1;
                if (state_q == S_FINISH) pause_q <= 1'b0;
                if (state_q == S_RD_WAIT && rdwait_last) begin
                    so_valid_q <= 1'b1;
                    so_data_q  <= hs_rdata;
                end
                if (state_q == S_RD_OUT && so_ready) so_valid_q <= 1'b0;
            end
        end
    end

    // Descriptor table, writable only while idle.
    always_ff @(posedge clk48M or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                base_q[i] <= '0;
                len_q[i]  <= '0;
            end
        end else if (state_q == S_IDLE && cfg_we) begin
            base_q[cfg_idx] <= cfg_base;
            len_q[cfg_idx]  <= cfg_len;
        end
    end

    // Output decode from state.
    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_FINISH);
        si_ready = (state_q == S_WR);
        hs_we    = (state_q == S_WR) && si_valid;
        hs_wdata = (state_q == S_WR) ? si_data : 8'h00;
        hs_addr  = base_cur + {8'h00, off_q};
    end

    assign pause_req = pause_q;
    assign err       = err_q;
    assign so_valid  = so_valid_q;
    assign so_data   = so_data_q;
endmodule

// File: doc/segasys1_hiscore_seq.md
Name: segasys1_hiscore_seq

Overview:
- Sequencer that owns the hiscore port (HSAD/HSDI/HSWE/HSDO) of the System 1 core and performs whole-table save or restore transfers.
- Freezes the core via a pause request, aligned to the rising edge of VBLK.
- Walks up to NREG address regions programmed by the host.
- Moves bytes between the core and a host byte stream using valid/ready handshakes.

Parameters:
- NREG, 4: number of region descriptors. Must be a power of 2, at least 2.
- RDLAT, 2: cycles from HSAD presented to HSDO valid (core RAM read latency). Range 1..7.
- SETTLE, 3: cycles waited after pause_req asserts before the first access.

Ports:
- clk48M  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cfg_we  in  1  write descriptor cfg_idx (ignored while busy)
- cfg_idx  in  log2(NREG)  descriptor index
- cfg_base  in  16  region start address
- cfg_len  in  9  region byte count, 0..256; 0 = region disabled
- start_save  in  1  single-cycle pulse: core to stream
- start_load  in  1  single-cycle pulse: stream to core
- abort  in  1  cancel transfer
- vblank  in  1  VBLK from core video
- busy  out  1  transfer in progress
- done  out  1  single-cycle pulse on normal completion
- err  out  1  sticky abort flag
- pause_req  out  1  to core pause logic (PAUSE_N = ~pause_req)
- hs_addr  out  16  to HSAD
- hs_wdata  out  8  to HSDI
- hs_we  out  1  to HSWE
- hs_rdata  in  8  from HSDO
- so_data  out  8  save stream data
- so_valid  out  1  save stream valid
- so_ready  in  1  save stream ready
- si_data  in  8  load stream data
- si_valid  in  1  load stream valid
- si_ready  out  1  load stream ready

Behaviour:
Reset and idle:
- On reset_n low, asynchronously: all outputs 0, state IDLE.
- Descriptors reset to base=0, len=0.
- cfg_we in IDLE writes the descriptor; it takes effect for the next start.

States: IDLE, WAITVB, SETTLE, NEXTREG, RD_ADDR, RD_WAIT, RD_OUT, WR, FINISH.
- IDLE: start_save or start_load latches the direction and clears err, then goes to WAITVB. start_save wins if both pulse in the same cycle. Starts while busy are ignored.
- busy=1 in every state except IDLE.
- WAITVB: waits for a vblank 0->1 edge, sampled as the registered previous value vs. current. On the edge, pause_req<=1 and state goes to SETTLE. A start issued while vblank is already high waits for the next edge.
- SETTLE: counts SETTLE cycles, then sets reg=0, offset=0 and goes to NEXTREG.
- NEXTREG: if reg==NREG, go to FINISH. Else if len[reg]==0, increment reg and stay (one cycle per skipped descriptor). Else go to RD_ADDR for save or WR for load.
- hs_addr = base[reg] + offset, mod 2^16; addresses wrap 0xFFFF->0x0000. offset is 8-bit wide plus a terminal compare against len-1.
- RD_ADDR: drives hs_addr for 1 cycle, then goes to RD_WAIT.
- RD_WAIT: holds hs_addr for RDLAT cycles. On the last cycle it captures hs_rdata into so_data, sets so_valid=1 and goes to RD_OUT.
- RD_OUT: so_data and so_valid hold until so_ready. On the handshake cycle, so_valid<=0 and offset increments. If the last byte of the region is done, reg++, offset=0 and go to NEXTREG; else go to RD_ADDR.
- Save throughput is at most 1 byte per RDLAT+2 cycles.
- WR: si_ready=1. On si_valid&si_ready: hs_we=1 for exactly that cycle, with hs_addr and hs_wdata=si_data valid in the same cycle, and offset advances as in RD_OUT. si_ready=0 outside WR.
- FINISH: pause_req<=0, done=1 for 1 cycle, then IDLE.
- hs_we=0 in every state other than WR.

Abort:
- abort in any non-IDLE state: next cycle state=IDLE, pause_req=0, so_valid=0, si_ready=0, hs_we=0, err=1, no done.
- abort in IDLE is ignored.
- err clears on the next accepted start.

Other rules:
- pause_req stays at 1 continuously from the WAITVB edge until FINISH or abort; it never drops mid-region.
- vblank is ignored after WAITVB.
- An all-disabled table completes as: WAITVB, SETTLE, NEXTREG x NREG, FINISH, with no hs_we and no stream beats.
- Byte order: descriptors in ascending index, addresses ascending within each region.

Test Plan:
- Save wait and latency: desc0={0xC000,3}, other descriptors len 0, RDLAT=2, core RAM C000..C002=11,22,33, so_ready=1, start_save mid-frame. Required:
  - no pause_req before the vblank edge;
  - stream beats 11,22,33;
  - hs_addr C000,C001,C002;
  - done exactly once;
  - pause_req low after done.
- Load: desc1={0xD000,2}, start_load, si_data 5A then A5 with valid gaps. Required: exactly two hs_we pulses, at D000=5A and D001=A5; si_ready high only in WR.
- Backpressure and wrap: desc0={0xFFFF,2}, hold so_ready=0 for 10 cycles. Required: so_data and so_valid stable throughout; addresses FFFF then 0000.
- Max length and skipping: len=256 on desc0, len=0 on the rest. Required: 256 beats, then 3 NEXTREG skip cycles, then done.
- Simultaneous start: start_save and start_load in the same cycle. Required: save direction taken. A start pulse while busy is ignored.
- Abort and reset: abort during RD_OUT. Required next cycle: pause_req=0, err=1, busy=0, no done. reset_n low mid-WR: all outputs 0 immediately.
